// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-tuple to machine-code encoder with legality check and 2-entry output FIFO
//
// Purpose: accepts decoded instruction fields (op, func={funct7,funct3}, rs1, rs2, rd, imm),
// checks them against the RV32I rules, packs legal tuples into 32-bit machine words tagged
// with a running byte address, and queues them in a 2-entry FIFO. Illegal tuples produce a
// one-cycle err pulse and bump a saturating error counter.
//
// Optional feature: define RV32M_EXT_EN to accept the RV32M multiply/divide group
// (R-type, funct7=0000001). Without it those funcs are rejected as illegal.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   clr            synchronous clear (address, FIFO, error counter); wins over push/pop
//   in_valid/in_ready           input handshake; in_ready = FIFO count < 2
//   op, func, rs1, rs2, rd, imm input field tuple
//   out_valid/out_ready         output handshake
//   out_instr, out_addr         FIFO head word and its byte address
//   err            one-cycle pulse after a rejected tuple
//   err_cnt        rejected-tuple count, saturating at 255

module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  op,
  input  logic [9:0]  func,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic [6:0] f7;
  logic [2:0] f3;
  assign f7 = func[9:3];
  assign f3 = func[2:0];

  // Immediate range checks: a value fits N signed bits when all bits above N-1 copy the sign.
  logic imm_s12, imm_s13, imm_s21, imm_u20, imm_sh;
  assign imm_s12 = (imm[31:11] == {21{imm[11]}});
  assign imm_s13 = (imm[31:12] == {20{imm[12]}});
  assign imm_s21 = (imm[31:20] == {12{imm[20]}});
  assign imm_u20 = (imm[31:20] == 12'h000);
  assign imm_sh  = (imm[31:5]  == 27'h0);

  logic        legal;
  logic [31:0] enc;

  always_comb begin
    legal = 1'b0;
    enc   = 32'h0;
    case (op)
      OP_R: begin
        enc   = {f7, rs2, rs1, f3, rd, op};
        legal = (f7 == F7_ZERO) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
`ifdef RV32M_EXT_EN
        if (f7 == F7_MULDIV) legal = 1'b1;
`else
        if (f7 == F7_MULDIV) legal = 1'b0;
`endif
      end
      OP_I: begin
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          // Shifts carry funct7 in the upper immediate field; only SRAI may use the alt funct7.
          enc   = {f7, imm[4:0], rs1, f3, rd, op};
          legal = imm_sh && ((f7 == F7_ZERO) || ((f3 == 3'b101) && (f7 == F7_ALT)));
        end else begin
          enc   = {imm[11:0], rs1, f3, rd, op};
          legal = (f7 == F7_ZERO) && imm_s12;
        end
      end
      OP_LOAD: begin
        enc   = {imm[11:0], rs1, f3, rd, op};
        legal = (f7 == F7_ZERO) && imm_s12 &&
                (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OP_JALR: begin
        enc   = {imm[11:0], rs1, f3, rd, op};
        legal = (f7 == F7_ZERO) && (f3 == 3'b000) && imm_s12;
      end
      OP_S: begin
        enc   = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        legal = (f7 == F7_ZERO) && imm_s12 && !f3[2] && (f3 != 3'b011);
      end
      OP_B: begin
        enc   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        legal = (f7 == F7_ZERO) && imm_s13 && !imm[0] &&
                (f3 != 3'b010) && (f3 != 3'b011);
      end
      OP_JAL: begin
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        legal = imm_s21 && !imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        enc   = {imm[19:0], rd, op};
        legal = imm_u20;
      end
      default: begin
        enc   = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

  // Two-entry FIFO of {instr, addr}
  logic [31:0] mem_instr [2];
  logic [31:0] mem_addr  [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [31:0] addr_cnt;
  logic        err_q;
  logic [7:0]  err_cnt_q;

  logic accept, push, pop;

  assign in_ready  = rst_n && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready && !clr;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready && !clr;

  // With the FIFO empty the outputs idle at 0 and the next address to be issued.
  assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'h0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr]  : addr_cnt;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_instr[0] <= 32'h0;
      mem_instr[1] <= 32'h0;
      mem_addr[0]  <= 32'h0;
      mem_addr[1]  <= 32'h0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      addr_cnt     <= BASE_ADDR;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else if (clr) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      addr_cnt  <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q <= accept && !legal;
      if (accept && !legal && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
      if (push) begin
        mem_instr[wr_ptr] <= enc;
        mem_addr[wr_ptr]  <= addr_cnt;
        wr_ptr            <= ~wr_ptr;
        addr_cnt          <= addr_cnt + 32'd4;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
